// File: rtl/pce_video_capture.sv
// Active-window capture for the HuC6260 VCE RGB333 output.
// Samples RGB, syncs and the pixel enable, crops a programmable window and streams pixels with
// start-of-frame / end-of-line markers through a small first-word-fall-through FIFO.
// Optional build macro PCE_CAPTURE_CRC_EN adds a per-frame CRC-16-CCITT of pushed pixels.
module pce_video_capture #(
  parameter int unsigned H_START    = 32,
  parameter int unsigned H_ACTIVE   = 256,
  parameter int unsigned V_START    = 20,
  parameter int unsigned V_ACTIVE   = 240,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       pix_ce,
  input  logic [2:0] VIDEO_R,
  input  logic [2:0] VIDEO_G,
  input  logic [2:0] VIDEO_B,
  input  logic       HSYNC_n,
  input  logic       VSYNC_n,
  input  logic       capture_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_data,
  output logic       out_sof,
  output logic       out_eol,
  output logic       overflow,
  output logic       busy
`ifdef PCE_CAPTURE_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        frame_crc_valid
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] HFirst = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] HLast  = CNT_W'(H_START + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VFirst = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] VLast  = CNT_W'(V_START + V_ACTIVE - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

  logic [8:0]       rgb_q;
  logic             ce_q, en_q, hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [CNT_W-1:0] h_cnt_q, v_cnt_q, h_cur, v_cur, h_next;
  state_e           state_q, start_state;
  logic             hs_fall, vs_fall, arm, in_win, hit, last_pix;
  logic [10:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, pop, wr_en, drop;
  logic             overflow_q;

  // Input stage: every decision below is taken on these registered copies.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      rgb_q     <= '0;
      ce_q      <= 1'b0;
      en_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      rgb_q     <= {VIDEO_R, VIDEO_G, VIDEO_B};
      ce_q      <= pix_ce;
      en_q      <= capture_en;
      hs_q      <= HSYNC_n;
      vs_q      <= VSYNC_n;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
    end
  end

  // Current pixel position, window hit and FIFO handshake decode.
  always_comb begin
    hs_fall = hs_prev_q & ~hs_q;
    vs_fall = vs_prev_q & ~vs_q;
    arm     = vs_fall & en_q;
    h_cur   = hs_fall ? '0 : h_cnt_q;
    if (vs_fall)                           v_cur = '0;
    else if (hs_fall && v_cnt_q != CntMax) v_cur = v_cnt_q + 1'b1;
    else                                   v_cur = v_cnt_q;
    h_next  = (ce_q && h_cur != CntMax) ? h_cur + 1'b1 : h_cur;
    // A VSYNC fall decides the frame's fate in the same cycle, so pushes stop at once.
    if (vs_fall) start_state = en_q ? StArmed : StIdle;
    else         start_state = state_q;
    in_win   = (h_cur >= HFirst) && (h_cur <= HLast) && (v_cur >= VFirst) && (v_cur <= VLast);
    hit      = ce_q && in_win && (start_state != StIdle);
    last_pix = hit && (h_cur == HLast) && (v_cur == VLast);
    pop      = out_valid & out_ready;
    full     = (count_q == (AW + 1)'(FIFO_DEPTH));
    wr_en    = hit & (~full | pop);
    drop     = hit & full & ~pop;
  end

  // Counters and capture FSM.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      state_q <= StIdle;
    end else begin
      h_cnt_q <= h_next;
      v_cnt_q <= v_cur;
      if (last_pix) state_q <= StIdle;
      else if (hit) state_q <= StCapture;
      else          state_q <= start_state;
    end
  end

  // Sticky drop flag; only a VSYNC fall that arms a new capture clears it.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N)  overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
    else if (arm)  overflow_q <= 1'b0;
  end

  // Output FIFO; a push into a full FIFO is accepted when the head pops in the same cycle.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {(h_cur == HFirst) && (v_cur == VFirst), h_cur == HLast, rgb_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_sof   = mem_q[rd_ptr_q][10];
  assign out_eol   = mem_q[rd_ptr_q][9];
  assign out_data  = mem_q[rd_ptr_q][8:0];
  assign overflow  = overflow_q;
  assign busy      = (state_q == StCapture);

`ifdef PCE_CAPTURE_CRC_EN
  logic [15:0] crc_q, crc_base, crc_new;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [8:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 8; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // Running CRC over accepted pixels; restarts whenever a capture is armed.
  always_comb begin
    crc_base = arm ? 16'hFFFF : crc_q;
    crc_new  = wr_en ? crc_step(crc_base, rgb_q) : crc_base;
  end

  // Publish the CRC of a completed frame with a one-cycle strobe.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      crc_q           <= 16'hFFFF;
      frame_crc       <= '0;
      frame_crc_valid <= 1'b0;
    end else begin
      crc_q           <= crc_new;
      frame_crc_valid <= last_pix;
      if (last_pix) frame_crc <= crc_new;
    end
  end
`endif

endmodule
